// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: request and response handshake bundle between the requesters and fpu_arbiter
interface fpu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_status
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_status
    );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one fpu adder between two requesters; statistics counters enabled by FPU_ARB_STATS_EN
module fpu_arbiter #(
    parameter int FPU_LATENCY = 5,
    parameter int CNT_W       = 16
) (
    input  logic             clock100KHz,
    input  logic             reset,
    fpu_arbiter_if.slave     bus,
    output logic [31:0]      fpu_op_a,
    output logic [31:0]      fpu_op_b,
    output logic             fpu_reset_n,
    input  logic [31:0]      fpu_data_in,
    input  logic [3:0]       fpu_status_in,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_flags
);
    localparam int LAT_W = $clog2(FPU_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT = LAT_W'(FPU_LATENCY);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} state_t;

    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic             last_grant;
    logic             grant0;
    logic             grant1;

    assign grant0 = !reset && state == IDLE && bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = !reset && state == IDLE && bus.req1_valid && (!bus.req0_valid || !last_grant);
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // accept one request, pulse the fpu reset to realign its phase, then wait out the latency
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            last_grant     <= 1'b1;
            fpu_reset_n    <= 1'b0;
            fpu_op_a       <= '0;
            fpu_op_b       <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_status <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fpu_reset_n <= !(grant0 || grant1);
                    if (grant0 || grant1) begin
                        fpu_op_a   <= grant1 ? bus.req1_a : bus.req0_a;
                        fpu_op_b   <= grant1 ? bus.req1_b : bus.req0_b;
                        bus.rsp_id <= grant1;
                        last_grant <= grant1;
                        state      <= ALIGN;
                    end
                end
                ALIGN: begin
                    fpu_reset_n <= 1'b1;
                    cnt         <= '0;
                    state       <= RUN;
                end
                RUN: begin
                    if (cnt == LAT) begin
                        bus.rsp_data   <= fpu_data_in;
                        bus.rsp_status <= fpu_status_in;
                        bus.rsp_valid  <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPU_ARB_STATS_EN
    // saturating counts of delivered responses and of those carrying a nonzero status
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            stat_ops   <= '0;
            stat_flags <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            stat_ops   <= &stat_ops ? stat_ops : stat_ops + 1'b1;
            stat_flags <= (bus.rsp_status == 4'd0 || &stat_flags) ? stat_flags : stat_flags + 1'b1;
        end
    end
`else
    assign stat_ops   = '0;
    assign stat_flags = '0;
`endif
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed vector bench for fpu_arbiter with a phase-sensitive fpu model
module tb_fpu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fpu_op_a;
    logic [31:0] fpu_op_b;
    logic        fpu_reset_n;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic [3:0]  fpu_st = 4'd0;
    logic [15:0] stat_ops;
    logic [15:0] stat_flags;
    int          phase = 0;
    int          passed = 0;
    int          total = 0;
    int          exp_ops = 0;
    int          exp_flags = 0;

    fpu_arbiter_if bus ();

    fpu_arbiter #(.FPU_LATENCY(5), .CNT_W(16)) dut (
        .clock100KHz  (clk),
        .reset        (rst),
        .bus          (bus),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_reset_n  (fpu_reset_n),
        .fpu_data_in  (fpu_data),
        .fpu_status_in(fpu_status),
        .stat_ops     (stat_ops),
        .stat_flags   (stat_flags)
    );

    always #5 clk = ~clk;

    // fpu model: result only valid exactly five edges after its reset is released
    always @(posedge clk) phase <= !fpu_reset_n ? 0 : (phase >= 7 ? 7 : phase + 1);
    assign fpu_data   = phase == 5 ? fpu_op_a + fpu_op_b : 32'hDEAD0000 | 32'(phase);
    assign fpu_status = phase == 5 ? fpu_st : 4'hF;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  st;
        logic        exp_id;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_op(input vec_t v, input int hold);
        int n;
        int lows;
        logic busy;
        logic got1;
        logic bad;
        logic [31:0] ea;
        logic [31:0] eb;
        bus.req0_valid = v.v0;
        bus.req0_a     = v.a0;
        bus.req0_b     = v.b0;
        bus.req1_valid = v.v1;
        bus.req1_a     = v.a1;
        bus.req1_b     = v.b1;
        fpu_st         = v.st;
        bus.rsp_ready  = hold == 0;
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 32'(n < 20), 32'd1);
        chk("grant_excl", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
        chk("grant_id", 32'(bus.req1_ready), 32'(v.exp_id));
        got1 = bus.req1_ready;
        ea = got1 ? v.a1 : v.a0;
        eb = got1 ? v.b1 : v.b0;
        @(negedge clk);
        if (got1) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
        chk("op_a", fpu_op_a, ea);
        chk("op_b", fpu_op_b, eb);
        n = 0;
        lows = 0;
        busy = 1'b0;
        while (!bus.rsp_valid && n < 30) begin
            lows += int'(!fpu_reset_n);
            busy |= bus.req0_ready | bus.req1_ready;
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd7);
        chk("rst_pulse", 32'(lows), 32'd1);
        chk("busy_ready", 32'(busy), 32'd0);
        chk("rsp_id", 32'(bus.rsp_id), 32'(v.exp_id));
        chk("rsp_data", bus.rsp_data, v.exp_data);
        chk("rsp_status", 32'(bus.rsp_status), 32'(v.st));
        chk("op_hold", 32'(fpu_op_a == ea && fpu_op_b == eb), 32'd1);
        if (hold > 0) begin
            bad = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                bad |= !bus.rsp_valid || bus.rsp_id != v.exp_id || bus.rsp_data != v.exp_data ||
                       bus.rsp_status != v.st || bus.req0_ready || bus.req1_ready;
            end
            chk("rsp_hold", 32'(bad), 32'd0);
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        exp_ops++;
        if (v.st != 4'd0) exp_flags++;
    endtask

    initial begin
        vec_t hv;
        logic seen;
        vecs[0] = '{1'b1, 1'b0, 32'h40000000, 32'h40000000, 32'h0, 32'h0, 4'd0, 1'b0, 32'h80000000};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h3F800000, 32'h3F800000, 4'd1, 1'b1, 32'h7F000000};
        vecs[2] = '{1'b1, 1'b1, 32'h00000001, 32'h00000002, 32'h00000010, 32'h00000020, 4'd2, 1'b0, 32'h00000003};
        vecs[3] = '{1'b1, 1'b1, 32'h00000001, 32'h00000002, 32'h00000010, 32'h00000020, 4'd2, 1'b1, 32'h00000030};
        vecs[4] = '{1'b1, 1'b1, 32'h12345678, 32'h11111111, 32'hFFFFFFFF, 32'h00000001, 4'd3, 1'b0, 32'h23456789};
        vecs[5] = '{1'b1, 1'b1, 32'h12345678, 32'h11111111, 32'hFFFFFFFF, 32'h00000001, 4'd2, 1'b1, 32'h00000000};
        vecs[6] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'hC0000000, 32'h00800000, 4'd0, 1'b1, 32'hC0800000};
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_fpu_reset_n", 32'(fpu_reset_n), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        chk("rst_rsp_fields", 32'({bus.rsp_id, bus.rsp_status}) | bus.rsp_data, 32'd0);
        chk("rst_ops", fpu_op_a | fpu_op_b, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_fpu_reset_n", 32'(fpu_reset_n), 32'd1);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_stats", 32'(stat_ops) | 32'(stat_flags), 32'd0);

        bus.req0_valid = 1'b1;
        bus.req0_a     = 32'h3F800000;
        bus.req0_b     = 32'h40000000;
        #1;
        chk("abort_grant", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_fpu_reset_n", 32'(fpu_reset_n), 32'd0);
        chk("abort_ops_cleared", fpu_op_a | fpu_op_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        exp_flags = 0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        hv = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h00001000, 32'h00000234, 4'd2, 1'b1, 32'h00001234};
        do_op(hv, 0);

        for (int i = 0; i < 7; i++) do_op(vecs[i], 0);

        hv = '{1'b1, 1'b1, 32'h0000000A, 32'h00000005, 32'h00000100, 32'h00000200, 4'd2, 1'b0, 32'h0000000F};
        do_op(hv, 10);
        chk("bp_next_grant", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
        hv = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h00000100, 32'h00000200, 4'd0, 1'b1, 32'h00000300};
        do_op(hv, 0);

`ifdef FPU_ARB_STATS_EN
        chk("stat_ops", 32'(stat_ops), 32'(exp_ops));
        chk("stat_flags", 32'(stat_flags), 32'(exp_flags));
`else
        chk("stat_ops", 32'(stat_ops), 32'd0);
        chk("stat_flags", 32'(stat_flags), 32'd0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
